// File: rtl/multi_digit_timer.sv
// Multi-digit BCD up/down timer with run/stop/done control, prescaled tick,
// optional wrap at terminal count and registered seven-segment outputs.
module multi_digit_timer #(
   parameter int DIGITS  = 2,
   parameter int CLK_DIV = 25000000,
   parameter int WRAP    = 1
) (
   input  logic                  clk_50MHz,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [8*DIGITS-1:0]   seg,
   output logic                  running,
   output logic                  done,
   output logic                  tc_pulse
);

   localparam int                 PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0]      PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [4*DIGITS-1:0] MAX_COUNT = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [PW-1:0]         presc, presc_nxt;
   logic [4*DIGITS-1:0]   count_nxt;
   logic [4*DIGITS-1:0]   stepped;
   logic [4*DIGITS-1:0]   load_sat;
   logic [8*DIGITS-1:0]   seg_nxt;
   logic                  tc_nxt;
   logic                  tick;
   logic                  at_term;
   logic                  next_term;

   // Cascaded per-digit BCD step; the carry/borrow ripples only through digits that roll over.
   function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                     input logic              dir_up);
      logic [4*DIGITS-1:0] r;
      logic [3:0]          d;
      logic                c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (dir_up) begin
               if (d == 4'd9) r[4*i +: 4] = 4'd0;
               else begin
                  r[4*i +: 4] = d + 4'd1;
                  c           = 1'b0;
               end
            end else begin
               if (d == 4'd0) r[4*i +: 4] = 4'd9;
               else begin
                  r[4*i +: 4] = d - 4'd1;
                  c           = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   assign running   = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign tick      = (state == ST_RUN) && (presc == PRESC_LAST);
   assign stepped   = bcd_step(count_bcd, up);
   assign at_term   = up ? (count_bcd == MAX_COUNT) : (count_bcd == '0);
   assign next_term = up ? (stepped == MAX_COUNT) : (stepped == '0);

   always_comb begin
      load_sat = load_value;
      seg_nxt  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_value[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
         seg_nxt[8*i +: 8] = seg_code(count_bcd[4*i +: 4]);
      end
   end

   // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      count_nxt = count_bcd;
      presc_nxt = presc;
      tc_nxt    = 1'b0;
      if (clear) begin
         count_nxt = '0;
         presc_nxt = '0;
         if (state == ST_DONE) state_nxt = ST_STOP;
      end else if (load) begin
         count_nxt = load_sat;
         presc_nxt = '0;
         if (state == ST_DONE) state_nxt = ST_STOP;
      end else begin
         case (state)
            ST_STOP: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN: begin
               // Stop freezes the prescaler so a later start resumes mid-period.
               if (stop) state_nxt = ST_STOP;
               else if (tick) begin
                  presc_nxt = '0;
                  count_nxt = stepped;
                  if (WRAP != 0) tc_nxt = at_term;
                  else begin
                     tc_nxt = at_term || next_term;
                     if (next_term) state_nxt = ST_DONE;
                  end
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end
            ST_DONE: ;
            default: state_nxt = ST_STOP;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state     <= ST_STOP;
         presc     <= '0;
         count_bcd <= '0;
         tc_pulse  <= 1'b0;
         seg       <= {DIGITS{8'hC0}};
      end else begin
         state     <= state_nxt;
         presc     <= presc_nxt;
         count_bcd <= count_nxt;
         tc_pulse  <= tc_nxt;
         seg       <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_multi_digit_timer.sv
// Directed bench for multi_digit_timer: one WRAP=1 and one WRAP=0 instance share stimulus.
module tb_multi_digit_timer;

   logic        clk_50MHz = 1'b0;
   logic        reset, start, stop, clear, up, load;
   logic [7:0]  load_value;
   logic [7:0]  cnt_w, cnt_s;
   logic [15:0] seg_w, seg_s;
   logic        run_w, run_s, done_w, done_s, tc_w, tc_s;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   multi_digit_timer #(.DIGITS(2), .CLK_DIV(4), .WRAP(1)) dut_w (
      .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .up(up), .load(load), .load_value(load_value), .count_bcd(cnt_w), .seg(seg_w),
      .running(run_w), .done(done_w), .tc_pulse(tc_w)
   );

   multi_digit_timer #(.DIGITS(2), .CLK_DIV(4), .WRAP(0)) dut_s (
      .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .up(up), .load(load), .load_value(load_value), .count_bcd(cnt_s), .seg(seg_s),
      .running(run_s), .done(done_s), .tc_pulse(tc_s)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      return 8'(((n / 10) % 10) * 16 + (n % 10));
   endfunction

   function automatic logic [15:0] seg_of(input logic [7:0] b);
      return {SEG_TAB[int'(b[7:4])], SEG_TAB[int'(b[3:0])]};
   endfunction

   initial begin
      logic [7:0] exp_cnt, prev_cnt;
      reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      up = 1'b1; load = 1'b0; load_value = 8'h00;

      // Reset state
      step();
      check("rst_count", 32'(cnt_w), 32'h00);
      check("rst_seg", 32'(seg_w), 32'hC0C0);
      check("rst_running", 32'(run_w), 32'd0);
      check("rst_done", 32'(done_w), 32'd0);
      check("rst_tc", 32'(tc_w), 32'd0);

      // Count up 00..10, one step per 4 cycles, seg one cycle behind
      reset = 1'b0; up = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      check("up_running", 32'(run_w), 32'd1);
      prev_cnt = 8'h00;
      for (int k = 1; k <= 40; k++) begin
         step();
         exp_cnt = to_bcd(k / 4);
         check($sformatf("up_count_k%0d", k), 32'(cnt_w), 32'(exp_cnt));
         check($sformatf("up_seg_k%0d", k), 32'(seg_w), 32'(seg_of(prev_cnt)));
         check($sformatf("up_tc_k%0d", k), 32'(tc_w), 32'd0);
         prev_cnt = exp_cnt;
      end

      // Direction change mid-run: 10 -> 09 with a borrow
      up = 1'b0;
      step_n(3);
      check("dir_hold", 32'(cnt_w), 32'h10);
      step();
      check("dir_down_w", 32'(cnt_w), 32'h09);
      check("dir_down_s", 32'(cnt_s), 32'h09);

      // WRAP=1: 99 -> 00 with a single tc pulse, still running
      do_reset();
      up = 1'b1; load = 1'b1; load_value = 8'h99;
      step();
      load = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step_n(3);
      check("wrap_pre_count", 32'(cnt_w), 32'h99);
      check("wrap_pre_tc", 32'(tc_w), 32'd0);
      step();
      check("wrap_count", 32'(cnt_w), 32'h00);
      check("wrap_tc", 32'(tc_w), 32'd1);
      check("wrap_running", 32'(run_w), 32'd1);
      step();
      check("wrap_tc_clr", 32'(tc_w), 32'd0);
      check("wrap_running2", 32'(run_w), 32'd1);

      // WRAP=0: 03 down to 00, DONE, start ignored, clear -> STOP
      do_reset();
      up = 1'b0; load = 1'b1; load_value = 8'h03;
      step();
      load = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step_n(4);
      check("stop_cnt02", 32'(cnt_s), 32'h02);
      check("stop_tc02", 32'(tc_s), 32'd0);
      step_n(4);
      check("stop_cnt01", 32'(cnt_s), 32'h01);
      step_n(4);
      check("stop_cnt00", 32'(cnt_s), 32'h00);
      check("stop_tc", 32'(tc_s), 32'd1);
      check("stop_done", 32'(done_s), 32'd1);
      check("stop_running", 32'(run_s), 32'd0);
      step();
      check("stop_tc_clr", 32'(tc_s), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      step_n(4);
      check("done_ign_done", 32'(done_s), 32'd1);
      check("done_ign_run", 32'(run_s), 32'd0);
      check("done_ign_cnt", 32'(cnt_s), 32'h00);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_done", 32'(done_s), 32'd0);
      check("clr_running", 32'(run_s), 32'd0);
      check("clr_count", 32'(cnt_s), 32'h00);
      step_n(8);
      check("clr_hold_cnt", 32'(cnt_s), 32'h00);
      check("clr_hold_run", 32'(run_s), 32'd0);

      // start+stop together: stop wins, prescaler frozen and resumed
      do_reset();
      up = 1'b1; start = 1'b1; stop = 1'b1;
      step();
      check("ss_idle_run", 32'(run_w), 32'd0);
      stop = 1'b0;
      step();
      start = 1'b0;
      step_n(2);
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("ss_run_stop", 32'(run_w), 32'd0);
      step_n(5);
      check("ss_frozen_cnt", 32'(cnt_w), 32'h00);
      start = 1'b1;
      step();
      start = 1'b0;
      check("ss_resume_run", 32'(run_w), 32'd1);
      step();
      check("ss_resume_pre", 32'(cnt_w), 32'h00);
      step();
      check("ss_resume_tick", 32'(cnt_w), 32'h01);

      // Saturating load and seg encoding
      do_reset();
      load = 1'b1; load_value = 8'hA5;
      step();
      load = 1'b0;
      check("sat_count", 32'(cnt_w), 32'h95);
      step();
      check("sat_seg", 32'(seg_w), 32'h9092);
      load = 1'b1; load_value = 8'h3C;
      step();
      load = 1'b0;
      check("sat_low", 32'(cnt_w), 32'h39);

      // Reset with load and start on a tick cycle mid-run
      do_reset();
      up = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step_n(7);
      check("mid_count", 32'(cnt_w), 32'h01);
      reset = 1'b1; load = 1'b1; load_value = 8'h55; start = 1'b1;
      step();
      reset = 1'b0; load = 1'b0; start = 1'b0;
      check("mr_count", 32'(cnt_w), 32'h00);
      check("mr_running", 32'(run_w), 32'd0);
      check("mr_seg", 32'(seg_w), 32'hC0C0);
      check("mr_tc", 32'(tc_w), 32'd0);
      step_n(10);
      check("mr_hold_cnt", 32'(cnt_w), 32'h00);
      check("mr_hold_run", 32'(run_w), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_digit_timer.md
MULTI_DIGIT_TIMER -- requirements
Module: multi_digit_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning the number of BCD digits and display outputs (legal range 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 25000000, meaning clk_50MHz cycles per count tick (25000000 gives 2 Hz; legal range >= 2).
REQ-003 SHALL have parameter WRAP, default 1, meaning 1 = wrap at terminal count and 0 = stop at terminal count.
REQ-004 SHALL have port clk_50MHz, input, width 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, width 1: single-cycle request to begin or resume counting.
REQ-007 SHALL have port stop, input, width 1: single-cycle request to pause counting.
REQ-008 SHALL have port clear, input, width 1: sets the count to 0 and keeps the run state.
REQ-009 SHALL have port up, input, width 1: 1 = count up, 0 = count down; sampled on every tick.
REQ-010 SHALL have port load, input, width 1: loads load_value into the count.
REQ-011 SHALL have port load_value, input, width 4*DIGITS: BCD preset, digit 0 in bits [3:0].
REQ-012 SHALL have port count_bcd, output, width 4*DIGITS: current count in BCD, digit 0 = ones.
REQ-013 SHALL have port seg, output, width 8*DIGITS: seven-segment codes, digit i in bits [8i+7:8i].
REQ-014 SHALL have port running, output, width 1: high while the FSM is in RUN.
REQ-015 SHALL have port done, output, width 1: high while the FSM is in DONE.
REQ-016 SHALL have port tc_pulse, output, width 1: one-cycle pulse when a tick crosses or reaches a terminal count.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 only while in RUN.
- Tick asserts in the cycle the prescaler equals CLK_DIV-1; the prescaler then returns to 0.
- Prescaler holds its value in STOP and DONE.
REQ-018 FSM states SHALL be STOP, RUN and DONE.
- STOP->RUN on start.
- RUN->STOP on stop.
- RUN->DONE when WRAP=0 and a tick reaches the terminal count.
- DONE->STOP on clear or load.
- DONE ignores start and stop.
REQ-019 If start and stop are both asserted in the same cycle, stop SHALL win.
REQ-020 Per-cycle priority SHALL be: reset > clear > load > start/stop > tick.
- A tick in a cycle with clear or load is discarded.
- The prescaler resets to 0 on clear or load.
REQ-021 Each count update SHALL be a cascaded BCD increment or decrement.
- Up: digit 9 rolls to 0 and carries into the next digit.
- Down: digit 0 rolls to 9 and borrows from the next digit.
- No binary intermediate.
REQ-022 Terminal count SHALL be MAX (all digits 9) when up=1 and 0 when up=0.
REQ-023 With WRAP=1, a tick at the terminal count SHALL wrap the count and pulse tc_pulse.
- Up: MAX -> 0.
- Down: 0 -> MAX.
REQ-024 With WRAP=0, a tick reaching the terminal count SHALL update the count, pulse tc_pulse, and enter DONE.
REQ-025 If start is applied while the count already equals the terminal count, the FSM SHALL enter RUN; the first tick moves the count off the terminal value in the current direction.
REQ-026 Any load_value digit greater than 9 SHALL be loaded as 9.
REQ-027 Changing up mid-run SHALL take effect on the next tick with no count glitch.
REQ-028 seg SHALL be registered and lag count_bcd by exactly one cycle.
REQ-029 seg encoding SHALL be active-low, bits {dp,g,f,e,d,c,b,a}, with dp always 1.
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- Leading zeros are displayed, not blanked.
REQ-030 tc_pulse SHALL be high for exactly one cycle, coincident with the count update.

Reset
REQ-031 On reset, all of the following SHALL hold on the next rising edge, regardless of other inputs:
- count_bcd = 0
- prescaler = 0
- FSM = STOP
- running = 0, done = 0, tc_pulse = 0
- seg = all-digit C0
REQ-032 Reset asserted mid-run SHALL discard any pending tick; after release the block stays in STOP until start.

Verification
REQ-033 Bench SHALL use DIGITS=2, CLK_DIV=4 unless stated otherwise, and cover these scenarios:
- Reset, then start, up=1, 40 cycles -> count_bcd 0x00..0x10, one step per 4 cycles; seg0 tracks ones one cycle late.
- WRAP=1, load 0x99, start, up=1 -> next tick gives count 0x00, tc_pulse one cycle, running stays 1.
- WRAP=0, load 0x03, up=0, start -> count 02, 01, 00; then done=1, running=0; further start ignored; clear -> STOP, count 00.
- Running with start and stop asserted together -> STOP, prescaler frozen; a later start resumes from the frozen prescaler value.
- load_value 0xA5 with load -> count_bcd 0x95; seg = {90,92}.
- Reset asserted together with load and start mid-run -> count 00, STOP, seg {C0,C0}.
